// File: rtl/cgia_pkg.sv
// rtl/cgia_pkg.sv - shared mode encodings and bpp/ppw helpers for the pixel serializer
package cgia_pkg;

  typedef enum logic [1:0] {
    MODE_1BPP = 2'b00,
    MODE_2BPP = 2'b01,
    MODE_4BPP = 2'b10,
    MODE_8BPP = 2'b11
  } mode_e;

  function automatic int bpp_of(input logic [1:0] mode);
    return 1 << mode;
  endfunction

  function automatic int ppw_of(input logic [1:0] mode, input int data_w);
    return data_w >> mode;
  endfunction

endpackage

// File: rtl/pixel_hold_buffer.sv
// rtl/pixel_hold_buffer.sv - one-entry prefetch register with valid/ready write side and refill read side
module pixel_hold_buffer #(
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              full_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              full_q, full_d;

  // Write only when empty and refill only when full, so the two never collide.
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    if (flush_i) begin
      full_d = 1'b0;
    end else if (wr_valid_i && !full_q) begin
      data_d = wr_data_i;
      full_d = 1'b1;
    end else if (rd_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign wr_ready_o = ~full_q;
  assign rd_data_o  = data_q;
  assign full_o     = full_q;

endmodule

// File: rtl/pixel_serializer.sv
// rtl/pixel_serializer.sv - MSB-first word-to-pen serializer with prefetch, zoom, flush and underrun flag
module pixel_serializer
  import cgia_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int COLOR_W = 8,
  parameter int ZOOM_W  = 2
) (
  input  logic               dotclk_i,
  input  logic               reset_ni,
  input  logic               en_i,
  input  logic               flush_i,
  input  logic [1:0]         mode_i,
  input  logic [ZOOM_W-1:0]  zoom_i,
  input  logic [DATA_W-1:0]  dat_i,
  input  logic               dat_valid_i,
  output logic               dat_ready_o,
  input  logic [COLOR_W-1:0] index_xor_i,
  output logic [COLOR_W-1:0] color_o,
  output logic               underrun_o
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [ZOOM_W-1:0]  rep_cnt_q, rep_cnt_d;
  mode_e              mode_q, mode_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               underrun_q, underrun_d;

  logic               hold_full;
  logic [DATA_W-1:0]  hold_data;
  logic               refill;
  logic               emit;
  logic [DATA_W-1:0]  word;
  logic [1:0]         wmode;
  logic [CNT_W-1:0]   wcnt;
  logic [ZOOM_W-1:0]  wrep;

  function automatic logic [COLOR_W-1:0] pix_of(input logic [DATA_W-1:0] w,
                                                input logic [1:0]        m);
    logic [7:0] top;
    logic [7:0] p;
    top = w[DATA_W-1 -: 8];
    case (m)
      MODE_1BPP: p = {7'd0, top[7]};
      MODE_2BPP: p = {6'd0, top[7:6]};
      MODE_4BPP: p = {4'd0, top[7:4]};
      default:   p = top;
    endcase
    return COLOR_W'(p);
  endfunction

  pixel_hold_buffer #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk_i      (dotclk_i),
    .rst_ni     (reset_ni),
    .flush_i    (flush_i),
    .wr_data_i  (dat_i),
    .wr_valid_i (dat_valid_i),
    .wr_ready_o (dat_ready_o),
    .rd_i       (refill),
    .rd_data_o  (hold_data),
    .full_o     (hold_full)
  );

  always_comb begin
    sh_d       = sh_q;
    pix_cnt_d  = pix_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    mode_d     = mode_q;
    color_d    = '0;
    underrun_d = 1'b0;
    refill     = 1'b0;
    emit       = 1'b0;
    word       = sh_q;
    wmode      = mode_q;
    wcnt       = pix_cnt_q;
    wrep       = rep_cnt_q;

    if (flush_i) begin
      sh_d      = '0;
      pix_cnt_d = '0;
      rep_cnt_d = '0;
    end else if (!en_i) begin
      // frozen: shifter state holds, output blanked
    end else if (pix_cnt_q != '0) begin
      emit = 1'b1;
    end else if (hold_full) begin
      // Refill emits the first pixel of the held word on this same dot.
      refill = 1'b1;
      emit   = 1'b1;
      mode_d = mode_e'(mode_i);
      word   = hold_data;
      wmode  = mode_i;
      wcnt   = CNT_W'(ppw_of(mode_i, DATA_W));
      wrep   = '0;
    end else begin
      color_d    = index_xor_i;
      underrun_d = 1'b1;
    end

    if (emit) begin
      color_d = pix_of(word, wmode) ^ index_xor_i;
      if (wrep >= zoom_i) begin
        sh_d      = word << bpp_of(wmode);
        pix_cnt_d = wcnt - 1'b1;
        rep_cnt_d = '0;
      end else begin
        sh_d      = word;
        pix_cnt_d = wcnt;
        rep_cnt_d = wrep + 1'b1;
      end
    end
  end

  always_ff @(posedge dotclk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sh_q       <= '0;
      pix_cnt_q  <= '0;
      rep_cnt_q  <= '0;
      mode_q     <= MODE_1BPP;
      color_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      pix_cnt_q  <= pix_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      mode_q     <= mode_d;
      color_q    <= color_d;
      underrun_q <= underrun_d;
    end
  end

  assign color_o    = color_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_pixel_serializer.sv
// tb/tb_pixel_serializer.sv - directed and randomized checks of pixel_serializer against a pixel-queue model
module tb_pixel_serializer;

  localparam int DATA_W  = 16;
  localparam int COLOR_W = 8;
  localparam int ZOOM_W  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               en;
  logic               flush;
  logic [1:0]         mode;
  logic [ZOOM_W-1:0]  zoom;
  logic [DATA_W-1:0]  dat;
  logic               dat_valid;
  logic [COLOR_W-1:0] xr;
  logic               ready;
  logic [COLOR_W-1:0] color;
  logic               und;

  pixel_serializer #(
    .DATA_W  (DATA_W),
    .COLOR_W (COLOR_W),
    .ZOOM_W  (ZOOM_W)
  ) dut (
    .dotclk_i    (clk),
    .reset_ni    (rst_n),
    .en_i        (en),
    .flush_i     (flush),
    .mode_i      (mode),
    .zoom_i      (zoom),
    .dat_i       (dat),
    .dat_valid_i (dat_valid),
    .dat_ready_o (ready),
    .index_xor_i (xr),
    .color_o     (color),
    .underrun_o  (und)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: the current word is a queue of pixel values, each shown zoom+1 times.
  int              m_q[$];
  int              m_rep;
  bit              m_hfull;
  logic [DATA_W-1:0] m_hold;
  logic [COLOR_W-1:0] m_color;
  bit              m_und;
  bit              last_wr;

  task automatic model_reset();
    m_q.delete();
    m_rep   = 0;
    m_hfull = 0;
    m_hold  = '0;
    m_color = '0;
    m_und   = 0;
  endtask

  task automatic model_load(input logic [DATA_W-1:0] w, input logic [1:0] m);
    int bpp;
    bpp = 1 << m;
    for (int k = 0; k < DATA_W / bpp; k++)
      m_q.push_back((int'(w) >> (DATA_W - (k + 1) * bpp)) & ((1 << bpp) - 1));
  endtask

  task automatic model_emit();
    m_color = COLOR_W'(m_q[0]) ^ xr;
    if (m_rep >= int'(zoom)) begin
      void'(m_q.pop_front());
      m_rep = 0;
    end else begin
      m_rep++;
    end
    m_und = 0;
  endtask

  task automatic step(input string tag);
    bit wr;
    wr = dat_valid && !m_hfull && !flush;
    @(posedge clk);
    if (flush) begin
      m_q.delete();
      m_rep   = 0;
      m_hfull = 0;
      m_color = '0;
      m_und   = 0;
    end else if (!en) begin
      m_color = '0;
      m_und   = 0;
    end else if (m_q.size() > 0) begin
      model_emit();
    end else if (m_hfull) begin
      model_load(m_hold, mode);
      m_hfull = 0;
      model_emit();
    end else begin
      m_color = xr;
      m_und   = 1;
    end
    if (wr) begin
      m_hold  = dat;
      m_hfull = 1;
    end
    last_wr = wr;
    #1;
    check({tag, "/color"}, color, m_color);
    check({tag, "/underrun"}, und, m_und);
    check({tag, "/ready"}, ready, !m_hfull);
  endtask

  task automatic prefetch(input logic [DATA_W-1:0] w);
    en        = 1'b0;
    dat       = w;
    dat_valid = 1'b1;
    step("pf");
    dat_valid = 1'b0;
  endtask

  int e3[4] = '{8'h12, 8'h34, 8'h56, 8'h78};

  initial begin
    rst_n = 1'b0; en = 0; flush = 0; mode = 0; zoom = 0; dat = 0; dat_valid = 0; xr = 0;
    last_wr = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: reset values, then async reset mid-word
    step("t1");
    check("t1_color", color, 0);
    check("t1_ready", ready, 1);
    check("t1_und", und, 0);
    mode = 2'b00;
    prefetch(16'hFFFF);
    en = 1'b1;
    step("t1_run");
    dat = 16'hFFFF; dat_valid = 1'b1;
    step("t1_run");
    dat_valid = 1'b0;
    check("t1_pre_color", color, 1);
    check("t1_pre_ready", ready, 0);
    #3 rst_n = 1'b0;
    #1;
    check("t1_async_color", color, 0);
    check("t1_async_ready", ready, 1);
    check("t1_async_und", und, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    en = 1'b0;

    // 2: 1bpp AAAA, then one underrun dot
    mode = 2'b00; zoom = 0; xr = 8'h00;
    prefetch(16'hAAAA);
    en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step("t2");
      check("t2_px", color, (i % 2 == 0) ? 1 : 0);
      if (i == 0) check("t2_ready_after_refill", ready, 1);
    end
    step("t2_end");
    check("t2_und_color", color, 0);
    check("t2_und", und, 1);
    en = 1'b0;
    step("t2_off");

    // 3: 8bpp back-to-back words with no gap dot
    mode = 2'b11;
    prefetch(16'h1234);
    en = 1'b1;
    dat = 16'h5678; dat_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("t3");
      if (last_wr) dat_valid = 1'b0;
      check("t3_px", color, e3[i]);
      check("t3_und", und, 0);
    end

    // 4: 4bpp with zoom 2
    mode = 2'b10; zoom = 2;
    prefetch(16'h1234);
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step("t4");
      check("t4_px", color, i / 3 + 1);
    end

    // 5: index xor and underrun colour
    mode = 2'b11; zoom = 0; xr = 8'hF0;
    prefetch(16'h1234);
    en = 1'b1;
    step("t5"); check("t5_px0", color, 8'hE2);
    step("t5"); check("t5_px1", color, 8'hC4);
    step("t5"); check("t5_und_color", color, 8'hF0); check("t5_und", und, 1);

    // 6: freeze and flush
    mode = 2'b01; xr = 8'h00;
    prefetch(16'hE4E4);
    en = 1'b1;
    step("t6"); check("t6_px0", color, 3);
    step("t6"); check("t6_px1", color, 2);
    en = 1'b0;
    step("t6"); check("t6_off0", color, 0);
    step("t6"); check("t6_off1", color, 0);
    en = 1'b1;
    step("t6"); check("t6_px2", color, 1);
    flush = 1'b1;
    step("t6"); check("t6_flush", color, 0);
    flush = 1'b0;
    step("t6"); check("t6_und", und, 1); check("t6_ready", ready, 1);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      en    = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 63) == 0);
      mode  = 2'($urandom_range(0, 3));
      zoom  = ZOOM_W'($urandom_range(0, 3));
      xr    = COLOR_W'($urandom);
      if (!dat_valid || last_wr) begin
        dat_valid = ($urandom_range(0, 2) != 0);
        dat       = DATA_W'($urandom);
      end
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_serializer.md
Name: pixel_serializer

Overview:
- Parametrised successor to the CGIA dot shifter. Serialises fetched video words onto the color pen bus at 1/2/4/8 bpp, MSB-first.
- Adds a one-word prefetch holding register with a valid/ready handshake, automatic refill at word end, and horizontal pixel repeat (zoom).
- Adds line flush, display-enable freeze and underrun reporting.
- Sits between the video fetch unit and the palette/pen bus, clocked on the dot clock.

Parameters:
- DATA_W, 16, fetched word width; a multiple of 8, at least 8.
- COLOR_W, 8, color index width; at least 8.
- ZOOM_W, 2, repeat-count width; each pixel is shown zoom_i+1 dots.

Ports:
- dotclk_i  in  1  dot clock; all state changes on its rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- en_i  in  1  display active; 0 freezes the shifter and blanks the output.
- flush_i  in  1  synchronous clear of the shifter and holding register (start of line).
- mode_i  in  2  00=1bpp, 01=2bpp, 10=4bpp, 11=8bpp.
- zoom_i  in  ZOOM_W  repeat count minus one.
- dat_i  in  DATA_W  fetched word.
- dat_valid_i  in  1  dat_i valid.
- dat_ready_o  out  1  holding register empty; equals ~hold_full.
- index_xor_i  in  COLOR_W  XOR applied to the emitted index.
- color_o  out  COLOR_W  registered color index.
- underrun_o  out  1  one-dot pulse when a pixel is due but no data is present.

Behaviour:
- Reset (async, reset_ni=0): sh, hold, pix_cnt, rep_cnt, mode_q, color_o and underrun_o all go to 0; hold_full=0, so dat_ready_o=1. Reset clears mid-word state immediately, without waiting for a clock edge.
- Derived values: bpp = 1<<mode. PPW = DATA_W/bpp. pix(w) = w[DATA_W-1 -: bpp], zero-extended to COLOR_W.
- Handshake: at an edge with dat_valid_i & dat_ready_o, hold<=dat_i and hold_full<=1.
  - A write and a refill never happen on the same edge: a write needs hold_full=0, a refill needs hold_full=1.
  - The handshake also runs while en_i=0, so words can be prefetched during blanking.
- Priority at each edge: flush_i, then en_i, then normal operation.
- flush_i=1:
  - sh, pix_cnt and rep_cnt go to 0; hold_full goes to 0.
  - A write presented on the same edge is dropped.
  - color_o<=0 and underrun_o<=0.
- en_i=0: sh, pix_cnt, rep_cnt and mode_q hold their values; color_o<=0; underrun_o<=0.
- en_i=1, pix_cnt>0 (emit):
  - color_o <= pix(sh) ^ index_xor_i, using bpp from mode_q.
  - If rep_cnt >= zoom_i (advance): sh<=sh<<bpp, pix_cnt-=1, rep_cnt<=0.
  - Otherwise: rep_cnt+=1.
  - Because the test is >=, lowering zoom_i mid-pixel advances on the next dot.
- en_i=1, pix_cnt=0, hold_full=1 (refill):
  - mode_q<=mode_i.
  - The effective word is hold with PPW from mode_i; emit and advance exactly as above using it, and rep_cnt starts from 0.
  - hold_full<=0.
  - Result: back-to-back words stream with no gap dot.
- en_i=1, pix_cnt=0, hold_full=0 (underrun): color_o<=index_xor_i; underrun_o<=1; no other state changes.
- underrun_o is 0 on every edge not listed above.
- Mode changes take effect only at a word boundary; zoom_i changes take effect immediately.
- Pixel counter width is clog2(DATA_W)+1 bits.

Decomposition:
- cgia_pkg holds:
  - the mode encodings MODE_1BPP, MODE_2BPP, MODE_4BPP, MODE_8BPP;
  - function bpp_of(mode);
  - function ppw_of(mode, DATA_W).
- One sub-module, pixel_hold_buffer: the one-entry holding register with the valid/ready handshake and flush. The shift, repeat and emit logic stays in pixel_serializer.

Test Plan (DATA_W=16, COLOR_W=8, ZOOM_W=2):
1. Reset release with en_i=0 -> color_o=00, dat_ready_o=1, underrun_o=0. Assert reset_ni mid-word -> all outputs return to reset values before the next edge.
2. mode=00, zoom=0, xor=00, write AAAA, en=1 -> color_o 01,00 repeated for 16 dots. dat_ready_o=1 after the refill edge. Dot 17: color_o=00, underrun_o=1 for one dot.
3. mode=11, write 1234, then 5678 while the first word is displayed -> color_o 12,34,56,78 on consecutive dots, underrun_o never asserted.
4. mode=10, zoom=2, word 1234 -> color_o 01,01,01,02,02,02,03,03,03,04,04,04.
5. mode=11, xor=F0, word 1234 -> color_o E2,C4. Then an underrun dot -> color_o=F0, underrun_o=1.
6. mode=01, word E4E4:
   - First two dots -> 03,02.
   - en=0 for two dots -> 00,00.
   - en=1 -> 01.
   - flush_i=1 -> 00.
   - Next dot with en=1 -> underrun_o=1, dat_ready_o=1.
